price_entry_buffer: RTL and testbench

// - Collects keypad digits into a NUM_DIGITS-wide BCD price, then presents it to the vending/checkout logic.
// - Handshake: rdy is held with the price until the consumer acknowledges it.
// - Sits between the debounced keypad scanner and the price-compare/credit logic.
// - Successor to the fixed 3-digit entry block: parametrised depth and key codes, explicit digit count, enter-to-commit, ack handshake.

---
 rtl/price_entry_pkg.sv | 21 ++
 rtl/price_entry_buffer_if.sv | 31 +++
 rtl/price_digit_shifter.sv | 43 ++++
 rtl/price_entry_buffer.sv | 123 ++++++++++++
 tb/tb_price_entry_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/price_entry_pkg.sv
// Shared types and default key codes for the keypad price-entry buffer.
// Optional backspace support is enabled by defining PRICE_ENTRY_BACKSPACE_EN.
package price_entry_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StEntry,
      StReady
   } entry_state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [3:0] KEY_CLEAR_DEF = 4'hF;
   localparam logic [3:0] KEY_ENTER_DEF = 4'hE;
   localparam logic [3:0] KEY_BACK_DEF  = 4'hD;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/price_entry_buffer_if.sv
// Keypad-to-consumer bus of the price-entry buffer: key strobe/code in, BCD price with
// rdy/ack handshake out. The buffer uses the slave side.
interface price_entry_buffer_if #(
   parameter int unsigned NUM_DIGITS = 3
) ();

   localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);

   logic [4:0]              pressed_button;
   logic                    rdy_ack;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [CntW-1:0]         digit_count;
   logic                    rdy;

   modport master (
      output pressed_button,
      output rdy_ack,
      input  digits,
      input  digit_count,
      input  rdy
   );

   modport slave (
      input  pressed_button,
      input  rdy_ack,
      output digits,
      output digit_count,
      output rdy
   );

endinterface

// File: rtl/price_digit_shifter.sv
// NUM_DIGITS-wide BCD shift register: shift-in at the low digit, shift-right, clear, hold.
// Clear has priority over shift-in, which has priority over shift-right.
module price_digit_shifter
   import price_entry_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear_i,
   input  logic                    shift_in_i,
   input  logic                    shift_right_i,
   input  bcd_digit_t              digit_i,
   output logic [4*NUM_DIGITS-1:0] digits_o
);

   localparam int unsigned W = 4 * NUM_DIGITS;

   logic [W-1:0] digits_q, digits_d;

   always_comb begin
      digits_d = digits_q;
      if (clear_i) begin
         digits_d = '0;
      end else if (shift_in_i) begin
         // Truncating cast drops the oldest digit and also covers NUM_DIGITS == 1.
         digits_d = W'({digits_q, digit_i});
      end else if (shift_right_i) begin
         digits_d = digits_q >> 4;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         digits_q <= '0;
      end else begin
         digits_q <= digits_d;
      end
   end

   assign digits_o = digits_q;

endmodule

// File: rtl/price_entry_buffer.sv
// Collects keypad digits into a right-aligned BCD price and holds it with rdy until acked.
// Define PRICE_ENTRY_BACKSPACE_EN to make KEY_BACK drop the last digit during entry.
module price_entry_buffer
   import price_entry_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 3,
   parameter int unsigned AUTO_COMMIT = 1,
   parameter logic [3:0]  KEY_CLEAR   = KEY_CLEAR_DEF,
   parameter logic [3:0]  KEY_ENTER   = KEY_ENTER_DEF,
   parameter logic [3:0]  KEY_BACK    = KEY_BACK_DEF
) (
   input  logic clock,
   input  logic reset_n,
   price_entry_buffer_if.slave bus
);

   localparam int unsigned    CntW   = $clog2(NUM_DIGITS + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(NUM_DIGITS);

   entry_state_e    state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic            rdy_q, rdy_d;
   logic            sh_clear, sh_shift_in, sh_shift_right;
   logic            key_valid;
   logic [3:0]      key_code;
   logic [CntW-1:0] count_inc;

   assign key_valid = bus.pressed_button[4];
   assign key_code  = bus.pressed_button[3:0];
   assign count_inc = count_q + CntW'(1);

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      rdy_d          = rdy_q;
      sh_clear       = 1'b0;
      sh_shift_in    = 1'b0;
      sh_shift_right = 1'b0;

      unique case (state_q)
         StReady: begin
            // Price is frozen; only the consumer's ack releases it. Keys are dropped.
            if (bus.rdy_ack) begin
               sh_clear = 1'b1;
               count_d  = '0;
               rdy_d    = 1'b0;
               state_d  = StIdle;
            end
         end
         StIdle, StEntry: begin
            if (key_valid) begin
               if (is_digit(key_code)) begin
                  if (count_q < CntMax) begin
                     sh_shift_in = 1'b1;
                     count_d     = count_inc;
                     state_d     = StEntry;
                     if (AUTO_COMMIT != 0 && count_inc == CntMax) begin
                        state_d = StReady;
                        rdy_d   = 1'b1;
                     end
                  end
               end else if (key_code == KEY_CLEAR) begin
                  sh_clear = 1'b1;
                  count_d  = '0;
                  state_d  = StIdle;
               end else if (key_code == KEY_ENTER) begin
                  if (state_q == StEntry) begin
                     state_d = StReady;
                     rdy_d   = 1'b1;
                  end
`ifdef PRICE_ENTRY_BACKSPACE_EN
               end else if (key_code == KEY_BACK) begin
                  if (state_q == StEntry) begin
                     sh_shift_right = 1'b1;
                     count_d        = count_q - CntW'(1);
                     if (count_q == CntW'(1)) begin
                        state_d = StIdle;
                     end
                  end
`else
               end else if (key_code == KEY_BACK) begin
                  // KEY_BACK has no effect in this build.
`endif
               end
            end
         end
         default: begin
            sh_clear = 1'b1;
            count_d  = '0;
            rdy_d    = 1'b0;
            state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
         count_q <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rdy_q   <= rdy_d;
      end
   end

   price_digit_shifter #(
      .NUM_DIGITS(NUM_DIGITS)
   ) u_shifter (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear_i      (sh_clear),
      .shift_in_i   (sh_shift_in),
      .shift_right_i(sh_shift_right),
      .digit_i      (key_code),
      .digits_o     (bus.digits)
   );

   assign bus.digit_count = count_q;
   assign bus.rdy         = rdy_q;

endmodule

// File: tb/tb_price_entry_buffer.sv
// Bench for price_entry_buffer: an auto-commit and an enter-to-commit instance driven in lockstep.
// Directed table, hand sequences, then random traffic against a decimal-arithmetic model.
module tb_price_entry_buffer;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   price_entry_buffer_if #(.NUM_DIGITS(3)) bus_a ();
   price_entry_buffer_if #(.NUM_DIGITS(3)) bus_m ();

   price_entry_buffer #(
      .NUM_DIGITS (3),
      .AUTO_COMMIT(1)
   ) dut_a (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_a.slave)
   );

   price_entry_buffer #(
      .NUM_DIGITS (3),
      .AUTO_COMMIT(0)
   ) dut_m (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus_m.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: price kept as a decimal number plus digit count; index 0 auto, 1 manual.
   int m_val [2];
   int m_cnt [2];
   bit m_rdy [2];

   typedef struct {
      logic        rn;
      logic        sv;
      logic [3:0]  code;
      logic        ack;
      logic [11:0] a_dig;
      logic [1:0]  a_cnt;
      logic        a_rdy;
      logic [11:0] m_dig;
      logic [1:0]  m_cnt;
      logic        m_rdy;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int          x = v;
      for (int i = 0; i < 8; i++) begin
         r = r | (32'(x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_step(input int k, input logic rn, input logic sv, input logic [3:0] code,
                             input logic ack);
      if (!rn) begin
         m_val[k] = 0; m_cnt[k] = 0; m_rdy[k] = 0;
      end else if (m_rdy[k]) begin
         if (ack) begin
            m_val[k] = 0; m_cnt[k] = 0; m_rdy[k] = 0;
         end
      end else if (sv) begin
         if (code <= 4'd9) begin
            if (m_cnt[k] < 3) begin
               m_val[k] = m_val[k] * 10 + int'(code);
               m_cnt[k] = m_cnt[k] + 1;
               if (k == 0 && m_cnt[k] == 3) m_rdy[k] = 1;
            end
         end else if (code == 4'hF) begin
            m_val[k] = 0; m_cnt[k] = 0;
         end else if (code == 4'hE) begin
            if (m_cnt[k] > 0) m_rdy[k] = 1;
`ifdef PRICE_ENTRY_BACKSPACE_EN
         end else if (code == 4'hD) begin
            if (m_cnt[k] > 0) begin
               m_val[k] = m_val[k] / 10;
               m_cnt[k] = m_cnt[k] - 1;
            end
`endif
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic rn, input logic sv, input logic [3:0] code, input logic ack);
      reset_n              = rn;
      bus_a.pressed_button = {sv, code};
      bus_a.rdy_ack        = ack;
      bus_m.pressed_button = {sv, code};
      bus_m.rdy_ack        = ack;
      model_step(0, rn, sv, code, ack);
      model_step(1, rn, sv, code, ack);
      @(posedge clock);
      #1;
   endtask

   task automatic check_both(input string tag, input logic [11:0] ad, input logic [1:0] ac,
                             input logic ar, input logic [11:0] md, input logic [1:0] mc,
                             input logic mr);
      chk({tag, " auto digits"}, 32'(bus_a.digits), 32'(ad));
      chk({tag, " auto count"}, 32'(bus_a.digit_count), 32'(ac));
      chk({tag, " auto rdy"}, 32'(bus_a.rdy), 32'(ar));
      chk({tag, " man digits"}, 32'(bus_m.digits), 32'(md));
      chk({tag, " man count"}, 32'(bus_m.digit_count), 32'(mc));
      chk({tag, " man rdy"}, 32'(bus_m.rdy), 32'(mr));
   endtask

   task automatic check_model(input string tag);
      check_both(tag, 12'(to_bcd(m_val[0])), 2'(m_cnt[0]), m_rdy[0],
                 12'(to_bcd(m_val[1])), 2'(m_cnt[1]), m_rdy[1]);
   endtask

   task automatic add(input logic rn, input logic sv, input logic [3:0] code, input logic ack,
                      input logic [11:0] ad, input logic [1:0] ac, input logic ar,
                      input logic [11:0] md, input logic [1:0] mc, input logic mr);
      vec_t v;
      v = '{rn, sv, code, ack, ad, ac, ar, md, mc, mr};
      vq.push_back(v);
   endtask

   initial begin
      //   rn    sv    code  ack   auto: dig    cnt   rdy   man: dig    cnt   rdy
      add(1'b1, 1'b1, 4'h1, 1'b0, 12'h001, 2'd1, 1'b0, 12'h001, 2'd1, 1'b0);
      add(1'b1, 1'b1, 4'h0, 1'b0, 12'h010, 2'd2, 1'b0, 12'h010, 2'd2, 1'b0);
      add(1'b1, 1'b1, 4'h5, 1'b0, 12'h105, 2'd3, 1'b1, 12'h105, 2'd3, 1'b0);
      add(1'b1, 1'b0, 4'h0, 1'b0, 12'h105, 2'd3, 1'b1, 12'h105, 2'd3, 1'b0);
      add(1'b1, 1'b1, 4'h7, 1'b0, 12'h105, 2'd3, 1'b1, 12'h105, 2'd3, 1'b0);
      add(1'b1, 1'b1, 4'hF, 1'b0, 12'h105, 2'd3, 1'b1, 12'h000, 2'd0, 1'b0);
      add(1'b1, 1'b1, 4'h7, 1'b1, 12'h000, 2'd0, 1'b0, 12'h007, 2'd1, 1'b0);
      add(1'b1, 1'b1, 4'h4, 1'b0, 12'h004, 2'd1, 1'b0, 12'h074, 2'd2, 1'b0);
      add(1'b1, 1'b1, 4'h2, 1'b0, 12'h042, 2'd2, 1'b0, 12'h742, 2'd3, 1'b0);
      add(1'b1, 1'b1, 4'hE, 1'b0, 12'h042, 2'd2, 1'b1, 12'h742, 2'd3, 1'b1);
      add(1'b1, 1'b0, 4'h0, 1'b1, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);
      add(1'b1, 1'b1, 4'hE, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);
      add(1'b1, 1'b1, 4'h9, 1'b0, 12'h009, 2'd1, 1'b0, 12'h009, 2'd1, 1'b0);
      add(1'b1, 1'b1, 4'hF, 1'b0, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);
      add(1'b1, 1'b1, 4'h0, 1'b0, 12'h000, 2'd1, 1'b0, 12'h000, 2'd1, 1'b0);
      add(1'b1, 1'b1, 4'hA, 1'b0, 12'h000, 2'd1, 1'b0, 12'h000, 2'd1, 1'b0);
      add(1'b1, 1'b0, 4'h3, 1'b0, 12'h000, 2'd1, 1'b0, 12'h000, 2'd1, 1'b0);
      add(1'b1, 1'b1, 4'h1, 1'b0, 12'h001, 2'd2, 1'b0, 12'h001, 2'd2, 1'b0);
      add(1'b1, 1'b1, 4'h2, 1'b0, 12'h012, 2'd3, 1'b1, 12'h012, 2'd3, 1'b0);
      add(1'b1, 1'b1, 4'hE, 1'b0, 12'h012, 2'd3, 1'b1, 12'h012, 2'd3, 1'b1);
      add(1'b0, 1'b1, 4'h5, 1'b1, 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);

      drive(1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b0, 1'b0, 4'h0, 1'b0);
      check_both("reset", 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);

      foreach (vq[i]) begin
         drive(vq[i].rn, vq[i].sv, vq[i].code, vq[i].ack);
         check_both($sformatf("vec%0d", i), vq[i].a_dig, vq[i].a_cnt, vq[i].a_rdy,
                    vq[i].m_dig, vq[i].m_cnt, vq[i].m_rdy);
      end

      // Four digits into three slots: auto commits on the third, manual drops the fourth.
      drive(1'b1, 1'b1, 4'h1, 1'b0);
      drive(1'b1, 1'b1, 4'h2, 1'b0);
      drive(1'b1, 1'b1, 4'h3, 1'b0);
      drive(1'b1, 1'b1, 4'h4, 1'b0);
      check_both("sat4", 12'h123, 2'd3, 1'b1, 12'h123, 2'd3, 1'b0);
      drive(1'b1, 1'b1, 4'h8, 1'b0);
      check_both("sat5", 12'h123, 2'd3, 1'b1, 12'h123, 2'd3, 1'b0);
      drive(1'b1, 1'b1, 4'hE, 1'b0);
      check_both("sat_enter", 12'h123, 2'd3, 1'b1, 12'h123, 2'd3, 1'b1);
      drive(1'b0, 1'b0, 4'h0, 1'b1);
      check_both("sat_reset", 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);

      // Backspace sequence: 8, 3, BACK, BACK.
      drive(1'b1, 1'b1, 4'h8, 1'b0);
      drive(1'b1, 1'b1, 4'h3, 1'b0);
      drive(1'b1, 1'b1, 4'hD, 1'b0);
`ifdef PRICE_ENTRY_BACKSPACE_EN
      check_both("back1", 12'h008, 2'd1, 1'b0, 12'h008, 2'd1, 1'b0);
      drive(1'b1, 1'b1, 4'hD, 1'b0);
      check_both("back2", 12'h000, 2'd0, 1'b0, 12'h000, 2'd0, 1'b0);
`else
      check_both("back1", 12'h083, 2'd2, 1'b0, 12'h083, 2'd2, 1'b0);
      drive(1'b1, 1'b1, 4'hD, 1'b0);
      check_both("back2", 12'h083, 2'd2, 1'b0, 12'h083, 2'd2, 1'b0);
`endif
      drive(1'b0, 1'b0, 4'h0, 1'b0);

      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
         check_model($sformatf("rand%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
